emu_transactor: RTL
===================

Name: emu_transactor

Overview:
- Parametrised co-emulation transactor between the host byte bus and an arbitrary DUT in the emulation FPGA.
- The host writes stimulus bytes into shadow registers, then issues a GO command.
- The block applies the stimulus, clock-enables the DUT for a programmable number of cycles, captures the DUT outputs, and reports done/busy status.
- It replaces the fixed two-in/four-out, free-running transactor with generic byte counts, autonomous stepping, and a status/handshake register.

Parameters:
- N_IN, 2, number of stimulus bytes driven to the DUT (1..2^ADDR_W-2).
- N_OUT, 4, number of captured DUT output bytes (1..2^ADDR_W-2).
- ADDR_W, 4, host address width; top two addresses are reserved.
- LED_BIT, 3, bit of the step counter driven to clk_LED.

Ports:
- clk_emu  in  1  single clock for the transactor and the DUT (DUT is gated by dut_ce).
- reset  in  1  synchronous, active-high reset.
- Addr  in  ADDR_W  host register address.
- Data_In  in  8  host write data.
- wr_emu  in  1  write strobe; one write per cycle while high.
- Data_Out  out  8  registered host read data.
- stim_out  out  8*N_IN  stimulus to the DUT; byte i is bits [8i+7:8i].
- dut_in  in  8*N_OUT  DUT outputs to capture.
- dut_ce  out  1  DUT clock enable.
- busy  out  1  high while state is not IDLE.
- clk_LED  out  1  activity indicator.

Behaviour:
- Address map:
  - STEP_ADDR = 2^ADDR_W-2: step count S, 8 bits, read/write.
  - CMD_ADDR = 2^ADDR_W-1: write bit0=GO, bit1=CLR_ERR. Read returns status {busy, done, err, 5'b0}.
  - Write to addresses 0..N_IN-1 loads the shadow stimulus byte.
  - Read of addresses 0..N_OUT-1 returns the capture byte.
  - Any other read returns 0; any other write is ignored.
- Data_Out is registered: the mux of Addr is sampled every cycle, giving 1-cycle read latency independent of wr_emu.
- Reset values:
  - stim_out, shadow, capture, S, Data_Out: 0.
  - dut_ce, busy, done, err, step counter, LED counter: 0.
  - State: IDLE.
- FSM states: IDLE, LOAD, STEP, CAPTURE.
  - IDLE: a GO write in cycle t moves to LOAD in t+1 and clears done.
  - LOAD (t+1): stim_out <= shadow. Next state is STEP if S≠0, otherwise CAPTURE.
  - STEP: dut_ce=1 for exactly S consecutive cycles (t+2..t+1+S). Down-counter loaded with S in LOAD; exit to CAPTURE when the counter reaches 1.
  - CAPTURE (t+2+S): capture <= dut_in. Then go to IDLE and set done=1 from t+3+S.
- dut_ce is a Moore output, high only in STEP. busy = (state≠IDLE), also Moore.
- S is latched in LOAD. Writing STEP_ADDR or the shadow registers while busy is allowed and affects only the next GO.
- GO while busy is ignored and sets sticky err. CLR_ERR clears err. GO and CLR_ERR in the same write while idle: the run starts and err is cleared.
- Capture and S are 8-bit; the step counter never wraps, since S ≤ 255.
- The LED counter increments once per dut_ce cycle and wraps naturally; clk_LED = counter[LED_BIT].
- Reset mid-run: on the next edge everything returns to reset values and dut_ce=0 immediately. No partial capture occurs.

Decomposition:
- Package emu_pkg holds:
  - State enum (IDLE/LOAD/STEP/CAPTURE).
  - CMD bit indices (GO=0, CLR_ERR=1).
  - Status bit indices (busy=7, done=6, err=5).
  - Localparam helpers for STEP_ADDR/CMD_ADDR given ADDR_W.
- One sub-module, emu_step_ctrl: the FSM plus the step down-counter, producing dut_ce, busy, done, the load strobe and the capture strobe.
- Register file and read mux stay in the top level.

Test Plan:
- Reset then read CMD_ADDR → Data_Out=0x00 one cycle later; dut_ce=0, stim_out=0.
- Write shadow bytes 0x5A, 0xC3, S=3, GO at cycle t:
  - stim_out=0xC35A from t+2.
  - dut_ce high t+2..t+4.
  - Status reads 0x40 after t+6.
- S=0, GO with dut_in=0xDEADBEEF:
  - dut_ce never asserts.
  - Reads of addr 0..3 return EF, BE, AD, DE.
  - done set at t+3.
- GO during STEP with S=10 → run completes unchanged; status reads 0x60; CLR_ERR → 0x40.
- Assert reset in the 2nd STEP cycle (S=5) → dut_ce=0 next cycle, busy=0, capture remains 0, status 0x00.
- 16 runs with S=1, LED_BIT=3 → clk_LED toggles after the 8th and 16th dut_ce cycles.

Source files
------------

// File: rtl/emu_pkg.sv
// rtl/emu_pkg.sv - shared types and constants for the co-emulation transactor
//   Holds the step-controller state enum, command/status bit positions and
//   helpers that place the step and command registers at the top of the map.
package emu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_STEP    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Command register write bits
  localparam int CMD_GO      = 0;
  localparam int CMD_CLR_ERR = 1;

  // Status register read bits
  localparam int STAT_BUSY = 7;
  localparam int STAT_DONE = 6;
  localparam int STAT_ERR  = 5;

  // The two highest addresses of the host map are reserved for step/cmd.
  function automatic int step_addr_f(input int aw);
    return (1 << aw) - 2;
  endfunction

  function automatic int cmd_addr_f(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/emu_transactor_step_ctrl.sv
// rtl/emu_transactor_step_ctrl.sv - run sequencer: load, step S cycles, capture
//   clk      : transactor clock
//   reset    : synchronous active-high reset
//   go       : GO command strobe (only acted on while idle)
//   step     : programmed step count, sampled in LOAD
//   dut_ce   : DUT clock enable, high only in STEP
//   busy     : high whenever not idle
//   done     : set when a run finishes, cleared by the next GO
//   load_stb : high during LOAD (stimulus transfer)
//   cap_stb  : high during CAPTURE (DUT output capture)
module emu_transactor_step_ctrl
  import emu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] step,
  output logic       dut_ce,
  output logic       busy,
  output logic       done,
  output logic       load_stb,
  output logic       cap_stb
);

  state_t     state;
  logic [7:0] cnt;

  // Outputs are registered alongside the state so each one is a clean
  // Moore decode of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      dut_ce   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_stb <= 1'b0;
      cap_stb  <= 1'b0;
    end else begin
      load_stb <= 1'b0;
      cap_stb  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            done     <= 1'b0;
            load_stb <= 1'b1;
          end
        end
        ST_LOAD: begin
          cnt <= step;
          if (step != 8'd0) begin
            state  <= ST_STEP;
            dut_ce <= 1'b1;
          end else begin
            state   <= ST_CAPTURE;
            cap_stb <= 1'b1;
          end
        end
        ST_STEP: begin
          // Counter holds the remaining enabled cycles including this one.
          if (cnt == 8'd1) begin
            state   <= ST_CAPTURE;
            dut_ce  <= 1'b0;
            cap_stb <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/emu_transactor.sv
// rtl/emu_transactor.sv - host-byte-bus co-emulation transactor top level
//   clk_emu  : single clock for transactor and DUT
//   reset    : synchronous active-high reset
//   Addr     : host register address
//   Data_In  : host write data
//   wr_emu   : write strobe, one write per cycle
//   Data_Out : registered read data (1-cycle latency)
//   stim_out : stimulus bytes to the DUT, byte i at [8i+7:8i]
//   dut_in   : DUT output bytes to capture
//   dut_ce   : DUT clock enable
//   busy     : run in progress
//   clk_LED  : activity indicator, one bit of the enabled-cycle counter
module emu_transactor
  import emu_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int N_OUT   = 4,
  parameter int ADDR_W  = 4,
  parameter int LED_BIT = 3
) (
  input  logic                clk_emu,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [7:0]          Data_In,
  input  logic                wr_emu,
  output logic [7:0]          Data_Out,
  output logic [8*N_IN-1:0]   stim_out,
  input  logic [8*N_OUT-1:0]  dut_in,
  output logic                dut_ce,
  output logic                busy,
  output logic                clk_LED
);

  localparam logic [ADDR_W-1:0] STEP_ADDR = ADDR_W'(step_addr_f(ADDR_W));
  localparam logic [ADDR_W-1:0] CMD_ADDR  = ADDR_W'(cmd_addr_f(ADDR_W));

  logic [7:0]       shadow  [N_IN];
  logic [7:0]       capture [N_OUT];
  logic [7:0]       step_reg;
  logic             err;
  logic             done;
  logic             load_stb;
  logic             cap_stb;
  logic [LED_BIT:0] led_cnt;
  logic [7:0]       rd_data;
  logic             cmd_wr;
  logic             go;
  logic             clr_err;

  assign cmd_wr  = wr_emu && (Addr == CMD_ADDR);
  assign go      = cmd_wr && Data_In[CMD_GO];
  assign clr_err = cmd_wr && Data_In[CMD_CLR_ERR];
  assign clk_LED = led_cnt[LED_BIT];

  emu_transactor_step_ctrl u_step_ctrl (
    .clk      (clk_emu),
    .reset    (reset),
    .go       (go),
    .step     (step_reg),
    .dut_ce   (dut_ce),
    .busy     (busy),
    .done     (done),
    .load_stb (load_stb),
    .cap_stb  (cap_stb)
  );

  always_comb begin
    rd_data = 8'd0;
    if (Addr == STEP_ADDR) begin
      rd_data = step_reg;
    end else if (Addr == CMD_ADDR) begin
      rd_data[STAT_BUSY] = busy;
      rd_data[STAT_DONE] = done;
      rd_data[STAT_ERR]  = err;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (Addr == ADDR_W'(i)) rd_data = capture[i];
      end
    end
  end

  always_ff @(posedge clk_emu) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) shadow[i] <= 8'd0;
      for (int i = 0; i < N_OUT; i++) capture[i] <= 8'd0;
      stim_out <= '0;
      step_reg <= 8'd0;
      err      <= 1'b0;
      led_cnt  <= '0;
      Data_Out <= 8'd0;
    end else begin
      // Register writes are accepted even mid-run; they only matter at the next GO.
      if (wr_emu) begin
        if (Addr == STEP_ADDR) step_reg <= Data_In;
        for (int i = 0; i < N_IN; i++) begin
          if (Addr == ADDR_W'(i)) shadow[i] <= Data_In;
        end
      end
      if (go && busy) err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (load_stb) begin
        for (int i = 0; i < N_IN; i++) stim_out[8*i +: 8] <= shadow[i];
      end
      if (cap_stb) begin
        for (int i = 0; i < N_OUT; i++) capture[i] <= dut_in[8*i +: 8];
      end
      if (dut_ce) led_cnt <= led_cnt + 1'b1;
      Data_Out <= rd_data;
    end
  end

endmodule
